// File: rtl/knn_kbest_if.sv
// Streaming (distance, label) input channel into the K-best selector.
// The master side owns start/in_* and the selector returns in_ready.
interface knn_kbest_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LABEL_W = 8
);
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_dist;
    logic [LABEL_W-1:0] in_label;
    logic               in_last;

    modport master (output start, in_valid, in_dist, in_label, in_last,
                    input  in_ready);
    modport slave  (input  start, in_valid, in_dist, in_label, in_last,
                    output in_ready);
endinterface

// File: rtl/knn_kbest.sv
// Keeps the K smallest distances of a query sorted and, with KNN_VOTE_EN
// defined, runs a sequential majority vote over the kept labels.
module knn_kbest #(
    parameter  int unsigned DATA_W  = 32,
    parameter  int unsigned LABEL_W = 8,
    parameter  int unsigned K       = 4,
    localparam int unsigned IDX_W   = $clog2(K),
    localparam int unsigned CNT_W   = $clog2(K + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    knn_kbest_if.slave         in_if,
    input  logic [IDX_W-1:0]   rd_sel,
    output logic [DATA_W-1:0]  rd_dist,
    output logic [LABEL_W-1:0] rd_label,
    output logic               rd_valid,
    output logic [CNT_W-1:0]   n_valid,
    output logic               done,
    output logic [LABEL_W-1:0] result_label
);

    typedef enum logic [1:0] {IDLE, ACCEPT, VOTE} state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  dist_q  [K];
    logic [DATA_W-1:0]  dist_d  [K];
    logic [LABEL_W-1:0] label_q [K];
    logic [LABEL_W-1:0] label_d [K];
    logic [K-1:0]       valid_q, valid_d;
    logic [CNT_W-1:0]   n_valid_q, n_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               done_q, done_d;
    logic [K-1:0]       le;
    logic               accept;

`ifdef KNN_VOTE_EN
    logic [IDX_W-1:0]   vidx_q, vidx_d;
    logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;
    logic [LABEL_W-1:0] best_label_q, best_label_d;
    logic [LABEL_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]   vote_cnt;
    logic [CNT_W-1:0]   bc;
    logic [LABEL_W-1:0] bl;
`else
    logic               pend_q, pend_d;
`endif

    // le is a prefix mask because the list is sorted; its popcount is the insert position.
    always_comb begin
        for (int j = 0; j < K; j++) begin
            le[j] = valid_q[j] && (dist_q[j] <= in_if.in_dist);
        end
    end

    assign accept = in_if.in_valid && in_ready_q && !in_if.start;

`ifdef KNN_VOTE_EN
    // Occurrences of the label under the vote cursor among the valid entries.
    always_comb begin
        vote_cnt = '0;
        for (int j = 0; j < K; j++) begin
            vote_cnt = vote_cnt + CNT_W'(valid_q[j] && (label_q[j] == label_q[vidx_q]));
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        dist_d     = dist_q;
        label_d    = label_q;
        valid_d    = valid_q;
        n_valid_d  = n_valid_q;
        in_ready_d = in_ready_q;
        done_d     = 1'b0;
`ifdef KNN_VOTE_EN
        vidx_d       = vidx_q;
        best_cnt_d   = best_cnt_q;
        best_label_d = best_label_q;
        result_d     = result_q;
        bc           = best_cnt_q;
        bl           = best_label_q;
`else
        pend_d       = 1'b0;
        if (pend_q) begin
            done_d = 1'b1;
        end
`endif

        case (state_q)
            ACCEPT: begin
                if (accept) begin
                    if (!le[0]) begin
                        dist_d[0]  = in_if.in_dist;
                        label_d[0] = in_if.in_label;
                        valid_d[0] = 1'b1;
                    end
                    for (int j = 1; j < K; j++) begin
                        if (!le[j]) begin
                            if (le[j-1]) begin
                                dist_d[j]  = in_if.in_dist;
                                label_d[j] = in_if.in_label;
                                valid_d[j] = 1'b1;
                            end else begin
                                dist_d[j]  = dist_q[j-1];
                                label_d[j] = label_q[j-1];
                                valid_d[j] = valid_q[j-1];
                            end
                        end
                    end
                    if (!le[K-1] && (n_valid_q != CNT_W'(K))) begin
                        n_valid_d = n_valid_q + CNT_W'(1);
                    end
                    if (in_if.in_last) begin
                        in_ready_d = 1'b0;
`ifdef KNN_VOTE_EN
                        state_d      = VOTE;
                        vidx_d       = '0;
                        best_cnt_d   = '0;
                        best_label_d = '0;
`else
                        state_d      = IDLE;
                        pend_d       = 1'b1;
`endif
                    end
                end
            end
`ifdef KNN_VOTE_EN
            VOTE: begin
                // Strictly-greater update keeps ties on the nearer entry.
                if (valid_q[vidx_q] && (vote_cnt > best_cnt_q)) begin
                    bc = vote_cnt;
                    bl = label_q[vidx_q];
                end
                best_cnt_d   = bc;
                best_label_d = bl;
                if (vidx_q == IDX_W'(K - 1)) begin
                    result_d = bl;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    vidx_d = vidx_q + IDX_W'(1);
                end
            end
`endif
            default: ;
        endcase

        // start overrides everything, including an in-flight pair or vote.
        if (in_if.start) begin
            state_d    = ACCEPT;
            in_ready_d = 1'b1;
            done_d     = 1'b0;
            valid_d    = '0;
            n_valid_d  = '0;
            for (int j = 0; j < K; j++) begin
                dist_d[j]  = '0;
                label_d[j] = '0;
            end
`ifdef KNN_VOTE_EN
            result_d = '0;
`else
            pend_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            n_valid_q  <= '0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            for (int j = 0; j < K; j++) begin
                dist_q[j]  <= '0;
                label_q[j] <= '0;
            end
`ifdef KNN_VOTE_EN
            vidx_q       <= '0;
            best_cnt_q   <= '0;
            best_label_q <= '0;
            result_q     <= '0;
`else
            pend_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            n_valid_q  <= n_valid_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            for (int j = 0; j < K; j++) begin
                dist_q[j]  <= dist_d[j];
                label_q[j] <= label_d[j];
            end
`ifdef KNN_VOTE_EN
            vidx_q       <= vidx_d;
            best_cnt_q   <= best_cnt_d;
            best_label_q <= best_label_d;
            result_q     <= result_d;
`else
            pend_q       <= pend_d;
`endif
        end
    end

    logic sel_ok;
    assign sel_ok = ({1'b0, rd_sel} < (IDX_W + 1)'(K));

    assign in_if.in_ready = in_ready_q;
    assign rd_valid       = sel_ok ? valid_q[rd_sel] : 1'b0;
    assign rd_dist        = sel_ok ? dist_q[rd_sel]  : '0;
    assign rd_label       = sel_ok ? label_q[rd_sel] : '0;
    assign n_valid        = n_valid_q;
    assign done           = done_q;
`ifdef KNN_VOTE_EN
    assign result_label   = result_q;
`else
    assign result_label   = '0;
`endif

endmodule

// File: tb/tb_knn_kbest.sv
// Scoreboard bench for knn_kbest: a queue-based reference list and vote,
// compared by a monitor on every done pulse (honours KNN_VOTE_EN).
module tb_knn_kbest;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;
    localparam int unsigned K  = 4;
    localparam int unsigned IW = $clog2(K);
    localparam int unsigned CW = $clog2(K + 1);
`ifdef KNN_VOTE_EN
    localparam int unsigned LAT = K;
    localparam bit VOTE_ON = 1'b1;
`else
    localparam int unsigned LAT = 1;
    localparam bit VOTE_ON = 1'b0;
`endif

    typedef struct packed {
        logic [K-1:0][DW-1:0] d;
        logic [K-1:0][LW-1:0] l;
        logic [CW-1:0]        n;
        logic [LW-1:0]        res;
        logic [31:0]          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [IW-1:0] rd_sel = '0;
    logic [DW-1:0] rd_dist;
    logic [LW-1:0] rd_label;
    logic rd_valid;
    logic [CW-1:0] n_valid;
    logic done;
    logic [LW-1:0] result_label;

    int unsigned cyc = 0;
    int tests = 0;
    int fails = 0;
    exp_t sb[$];
    logic [DW-1:0] mdist[$];
    logic [LW-1:0] mlab[$];

    knn_kbest_if #(.DATA_W(DW), .LABEL_W(LW)) bif ();

    knn_kbest #(.DATA_W(DW), .LABEL_W(LW), .K(K)) dut (
        .clk(clk), .rst_n(rst_n), .in_if(bif.slave),
        .rd_sel(rd_sel), .rd_dist(rd_dist), .rd_label(rd_label),
        .rd_valid(rd_valid), .n_valid(n_valid), .done(done),
        .result_label(result_label)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference insert: position is the count of kept entries not farther than d.
    function automatic void model_insert(input logic [DW-1:0] d, input logic [LW-1:0] l);
        int pos = 0;
        foreach (mdist[i]) if (mdist[i] <= d) pos++;
        if (pos < K) begin
            mdist.insert(pos, d);
            mlab.insert(pos, l);
            if (mdist.size() > K) begin
                void'(mdist.pop_back());
                void'(mlab.pop_back());
            end
        end
    endfunction

    // Most frequent kept label; on equal frequency the nearer one wins.
    function automatic logic [LW-1:0] model_vote();
        int best_c = 0;
        logic [LW-1:0] best_l = '0;
        foreach (mlab[i]) begin
            int c = 0;
            foreach (mlab[j]) if (mlab[j] == mlab[i]) c++;
            if (c > best_c) begin
                best_c = c;
                best_l = mlab[i];
            end
        end
        return best_l;
    endfunction

    task automatic do_start();
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        mdist.delete();
        mlab.delete();
        check("in_ready_after_start", 64'(bif.in_ready), 64'd1);
        check("n_valid_after_start", 64'(n_valid), 64'd0);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [LW-1:0] l, input bit last);
        logic acc;
        exp_t e;
        bif.in_valid = 1'b1;
        bif.in_dist  = d;
        bif.in_label = l;
        bif.in_last  = last;
        acc = bif.in_ready && !bif.start;
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
        if (acc) begin
            model_insert(d, l);
            if (last) begin
                e = '0;
                for (int i = 0; i < K; i++) begin
                    if (i < mdist.size()) begin
                        e.d[i] = mdist[i];
                        e.l[i] = mlab[i];
                    end
                end
                e.n   = CW'(mdist.size());
                e.res = VOTE_ON ? model_vote() : '0;
                e.cyc = cyc + LAT;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        #1;
    endtask

    // Monitor: every done must match the oldest outstanding query.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 64'(done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    check("result_label", 64'(result_label), 64'(e.res));
                    check("n_valid", 64'(n_valid), 64'(e.n));
                    for (int i = 0; i < K; i++) begin
                        rd_sel = IW'(i);
                        #1;
                        check("rd_valid", 64'(rd_valid), 64'(i < e.n));
                        if (i < e.n) begin
                            check("rd_dist", 64'(rd_dist), 64'(e.d[i]));
                            check("rd_label", 64'(rd_label), 64'(e.l[i]));
                        end
                    end
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 64'(bif.in_ready), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_n_valid"}, 64'(n_valid), 64'd0);
        check({tag, "_result"}, 64'(result_label), 64'd0);
        check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        check({tag, "_rd_dist"}, 64'(rd_dist), 64'd0);
        check({tag, "_rd_label"}, 64'(rd_label), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bif.start = 1'b0; bif.in_valid = 1'b1; bif.in_last = 1'b0;
        bif.in_dist = 32'd5; bif.in_label = 8'd1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        bif.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sorted insertion with a dropped farthest pair.
        do_start();
        send(50, 1, 0); send(10, 2, 0); send(30, 3, 0); send(20, 2, 0); send(40, 1, 1);
        wait_drain();

        // Pair offered while idle must be ignored.
        send(1, 7, 1);
        check("idle_ignored_n_valid", 64'(n_valid), 64'd4);
        wait_drain();

        do_start(); send(7, 4, 0); send(7, 5, 1); wait_drain();
        do_start(); send(9, 3, 0); send(3, 6, 1); wait_drain();
        do_start(); send(1, 8'hA, 0); send(2, 8'hB, 0); send(3, 8'hA, 0); send(4, 8'hB, 1); wait_drain();

        // Abort mid-stream, then the largest representable distance.
        do_start(); send(4, 1, 0); send(2, 2, 0);
        do_start(); send(32'hFFFF_FFFF, 9, 1); wait_drain();

        // start coincident with a pair: the pair is discarded.
        do_start(); send(5, 1, 0);
        bif.start = 1'b1;
        send(2, 7, 0);
        bif.start = 1'b0;
        mdist.delete(); mlab.delete();
        check("start_wins_n_valid", 64'(n_valid), 64'd0);
        send(8, 3, 1); wait_drain();

        // Reset shortly after the last accept kills the pending result.
        do_start(); send(5, 1, 0); send(3, 2, 1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_reset_vals("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_n_valid", 64'(n_valid), 64'd0);
        check("post_reset_in_ready", 64'(bif.in_ready), 64'd0);

        for (int q = 0; q < 30; q++) begin
            do_start();
            n = $urandom_range(1, 9);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send(($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : DW'($urandom_range(0, 20)),
                     LW'($urandom_range(0, 3)), i == n - 1);
            end
            wait_drain();
        end

        repeat (5) @(posedge clk);
        #1;
        if (sb.size() != 0) check("leftover_expect", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
